// File: rtl/seven_seg_pkg.sv
// Shared segment codes, FSM state type and helpers for the seven-segment BCD driver.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seven_seg_pkg;

    // Active-low segment codes, bit0 = seg 0 ... bit6 = seg 6
    localparam logic [6:0] D0    = 7'b1000000;
    localparam logic [6:0] D1    = 7'b1111001;
    localparam logic [6:0] D2    = 7'b0100100;
    localparam logic [6:0] D3    = 7'b0110000;
    localparam logic [6:0] D4    = 7'b0011001;
    localparam logic [6:0] D5    = 7'b0010010;
    localparam logic [6:0] D6    = 7'b0000010;
    localparam logic [6:0] D7    = 7'b1011000;
    localparam logic [6:0] D8    = 7'b0000000;
    localparam logic [6:0] D9    = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    // Non-decimal nibbles never occur in a valid conversion; show a dash if they do
    function automatic logic [6:0] digit_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return D0;
            4'd1:    return D1;
            4'd2:    return D2;
            4'd3:    return D3;
            4'd4:    return D4;
            4'd5:    return D5;
            4'd6:    return D6;
            4'd7:    return D7;
            4'd8:    return D8;
            4'd9:    return D9;
            default: return DASH;
        endcase
    endfunction

    // 10^n evaluated at elaboration; 64 bits covers ten digits with headroom
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_digit_enc.sv
// One BCD nibble to an active-low seven-segment code, with a forced-blank input.
// Latency: combinational.
// Backpressure: none.
module seven_seg_digit_enc
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? BLANK : digit_to_seg(nibble);

endmodule

// File: rtl/seven_seg_bcd_driver.sv
// Binary to decimal seven-segment driver: serial double-dabble, one input bit per cycle; SEVEN_SEG_BLINK_EN adds per-digit blinking.
// Latency: outputs update IN_W+1 edges after the accept edge; one value per IN_W+2 cycles.
// Backpressure: o_ready only in IDLE; i_valid while busy is dropped, nothing is queued.
module seven_seg_bcd_driver
    import seven_seg_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
`ifdef SEVEN_SEG_BLINK_EN
    ,
    parameter int BLINK_DIV = 25_000_000
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [IN_W-1:0]       i_value,
    input  logic                  i_blank_lz,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [DIGITS-1:0]     i_blink_mask,
`endif
    output logic [DIGITS*7-1:0]   o_seven,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int          CNT_W   = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_t                 state;
    logic [IN_W-1:0]        shreg;
    logic [DIGITS*4-1:0]    bcd;
    logic [DIGITS*4-1:0]    bcd_adj;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   blank_lz_q;
    logic                   ovf_q;
    logic [DIGITS*7-1:0]    seg_q;
    logic [DIGITS*7-1:0]    enc_seg;
    logic [DIGITS-1:0]      blank_vec;
    logic                   above_zero;

    assign o_ready = (state == IDLE);

    // Add-3 correction on every nibble that would reach 10 or more after the shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Blank a digit when blanking is on and it and every digit above it are zero; ones digit always shows
    always_comb begin
        blank_vec  = '0;
        above_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above_zero   = above_zero && (bcd[4*k +: 4] == 4'd0);
            blank_vec[k] = blank_lz_q && above_zero && (k != 0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_enc
            seven_seg_digit_enc u_enc (
                .nibble (bcd[4*g +: 4]),
                .blank  (blank_vec[g]),
                .seg    (enc_seg[7*g +: 7])
            );
        end
    endgenerate

    // Control FSM: accept, shift IN_W bits through the BCD register, then latch the display
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            blank_lz_q <= 1'b0;
            ovf_q      <= 1'b0;
            seg_q      <= '1;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shreg      <= i_value;
                        blank_lz_q <= i_blank_lz;
                        ovf_q      <= (64'(i_value) > MAX_VAL);
                        bcd        <= '0;
                        bit_cnt    <= CNT_W'(IN_W - 1);
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Carries out of the top nibble are dropped; overflowed values show dashes anyway
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    if (bit_cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    seg_q      <= ovf_q ? {DIGITS{DASH}} : enc_seg;
                    o_overflow <= ovf_q;
                    o_done     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DIV_W-1:0] blink_cnt;
    logic             blink_phase;

    // Free-running divider: blink phase flips once every BLINK_DIV cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == DIV_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Masked digits go dark during the blink-on phase
    always_comb begin
        o_seven = seg_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (blink_phase && i_blink_mask[k]) begin
                o_seven[7*k +: 7] = BLANK;
            end
        end
    end
`else
    assign o_seven = seg_q;
`endif

endmodule

// File: tb/tb_seven_seg_bcd_driver.sv
// Bench for seven_seg_bcd_driver: two instances (16-bit/5-digit and 8-bit/2-digit) share one clock and reset.
// Directed and random values are checked against a decimal-arithmetic reference model.
module tb_seven_seg_bcd_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_valid = 1'b0;
    logic [15:0] drv_value = '0;
    logic        drv_blz = 1'b0;
    logic        sel = 1'b0;

    logic        a_valid, a_ready, a_done, a_ovf;
    logic [34:0] a_seven;
    logic        b_valid, b_ready, b_done, b_ovf;
    logic [13:0] b_seven;
    logic [4:0]  a_mask = '0;
    logic [1:0]  b_mask = '0;

    logic        c_ready, c_done, c_ovf;
    logic [69:0] c_seven;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    assign a_valid = drv_valid & ~sel;
    assign b_valid = drv_valid & sel;
    assign c_ready = sel ? b_ready : a_ready;
    assign c_done  = sel ? b_done  : a_done;
    assign c_ovf   = sel ? b_ovf   : a_ovf;
    assign c_seven = sel ? {56'd0, b_seven} : {35'd0, a_seven};

    seven_seg_bcd_driver #(
        .IN_W(16), .DIGITS(5)
`ifdef SEVEN_SEG_BLINK_EN
        , .BLINK_DIV(4)
`endif
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
        .i_value(drv_value), .i_blank_lz(drv_blz),
`ifdef SEVEN_SEG_BLINK_EN
        .i_blink_mask(a_mask),
`endif
        .o_seven(a_seven), .o_done(a_done), .o_overflow(a_ovf)
    );

    seven_seg_bcd_driver #(
        .IN_W(8), .DIGITS(2)
`ifdef SEVEN_SEG_BLINK_EN
        , .BLINK_DIV(4)
`endif
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
        .i_value(drv_value[7:0]), .i_blank_lz(drv_blz),
`ifdef SEVEN_SEG_BLINK_EN
        .i_blink_mask(b_mask),
`endif
        .o_seven(b_seven), .o_done(b_done), .o_overflow(b_ovf)
    );

    // Reference: decimal digits by division, dashes above 10^nd-1, leading-zero blanking above the top nonzero digit
    function automatic logic [69:0] model_seg(input longint unsigned v, input bit blz, input int nd);
        logic [69:0]      r;
        longint unsigned  p, t;
        int               msd;
        int               d [10];
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        if (v >= p) begin
            for (int k = 0; k < nd; k++) r[7*k +: 7] = 7'b0111111;
            return r;
        end
        t   = v;
        msd = 0;
        for (int k = 0; k < nd; k++) begin
            d[k] = int'(t % 10);
            t    = t / 10;
            if (d[k] != 0) msd = k;
        end
        for (int k = 0; k < nd; k++) begin
            r[7*k +: 7] = (blz && k > msd) ? 7'b1111111 : seg_tab[d[k]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion on the selected instance; optional poke drives i_valid mid-conversion
    task automatic run(input bit s, input int v, input bit blz, input int poke);
        int              n, ready_lo, extra, nd, lat;
        logic [69:0]     exp;
        longint unsigned p;
        sel = s;
        nd  = s ? 2 : 5;
        lat = s ? 9 : 17;
        p   = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        exp = model_seg(longint'(v), blz, nd);
        n = 0;
        while (c_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_accept", 70'(c_ready), 70'd1);
        drv_value = 16'(v);
        drv_blz   = blz;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_value = 16'($urandom);
        drv_blz   = 1'($urandom);
        n = 0;
        ready_lo = 0;
        while (c_done !== 1'b1 && n < 40) begin
            if (c_ready === 1'b0) ready_lo++;
            if (poke >= 0 && n == 3) begin
                drv_valid = 1'b1;
                drv_value = 16'(poke);
            end else begin
                drv_valid = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        drv_valid = 1'b0;
        check("done_latency", 70'(n), 70'(lat));
        check("ready_low_cycles", 70'(ready_lo), 70'(lat));
        check("seven", c_seven, exp);
        check("overflow", 70'(c_ovf), 70'(longint'(v) >= p));
        @(posedge clk); #1;
        check("done_one_cycle", 70'(c_done), 70'd0);
        check("seven_hold", c_seven, exp);
        if (poke >= 0) begin
            extra = 0;
            repeat (lat + 2) begin
                @(posedge clk); #1;
                if (c_done === 1'b1) extra++;
            end
            check("busy_valid_ignored", 70'(extra), 70'd0);
            check("first_value_kept", c_seven, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int v;

        // Reset state on both instances
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_seven", 70'(a_seven), 70'(35'h7_FFFF_FFFF));
        check("rst_a_ready", 70'(a_ready), 70'd1);
        check("rst_a_done",  70'(a_done),  70'd0);
        check("rst_a_ovf",   70'(a_ovf),   70'd0);
        check("rst_b_seven", 70'(b_seven), 70'(14'h3FFF));
        rst = 1'b0;

        // Directed values on the 16-bit/5-digit instance
        run(1'b0, 12345, 1'b0, -1);
        run(1'b0, 7,     1'b1, -1);
        run(1'b0, 0,     1'b1, -1);
        run(1'b0, 0,     1'b0, -1);
        run(1'b0, 65535, 1'b1, -1);
        run(1'b0, 10001, 1'b1, -1);
        run(1'b0, 12345, 1'b0, 500);

        // Directed values on the 8-bit/2-digit instance, including the overflow boundary
        run(1'b1, 100, 1'b0, -1);
        run(1'b1, 99,  1'b0, -1);
        run(1'b1, 255, 1'b1, -1);
        run(1'b1, 5,   1'b1, -1);
        run(1'b1, 0,   1'b0, -1);

        // Random values with random blanking; bias toward short numbers to exercise blanking
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 999));
            run(1'b0, v, 1'($urandom), -1);
        end
        for (int i = 0; i < 8; i++) begin
            run(1'b1, int'($urandom_range(0, 255)), 1'($urandom), -1);
        end

        // Leave the small instance showing an overflow, then abort a conversion with reset
        run(1'b1, 200, 1'b0, -1);
        sel = 1'b0;
        drv_value = 16'd4321;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) ndone++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) ndone++;
        end
        rst = 1'b0;
        check("abort_seven_dark", 70'(a_seven), 70'(35'h7_FFFF_FFFF));
        check("abort_ready", 70'(a_ready), 70'd1);
        check("abort_b_ovf_cleared", 70'(b_ovf), 70'd0);
        repeat (20) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) ndone++;
        end
        check("abort_no_done", 70'(ndone), 70'd0);
        check("abort_seven_still_dark", 70'(a_seven), 70'(35'h7_FFFF_FFFF));

        // Conversion still works after the abort
        run(1'b0, 4321, 1'b0, -1);

`ifdef SEVEN_SEG_BLINK_EN
        begin
            int   last_t, t_now, runs;
            logic prev_blank;
            run(1'b0, 42, 1'b1, -1);
            a_mask = 5'b00001;
            last_t = -1;
            runs = 0;
            @(posedge clk); #1;
            prev_blank = (a_seven[6:0] === 7'b1111111);
            for (int c = 1; c < 24; c++) begin
                @(posedge clk); #1;
                check("blink_digit1", 70'(a_seven[13:7]), 70'(seg_tab[4]));
                t_now = c;
                if ((a_seven[6:0] === 7'b1111111) != prev_blank) begin
                    if (last_t >= 0) begin
                        check("blink_period", 70'(t_now - last_t), 70'd4);
                        runs++;
                    end
                    last_t = t_now;
                    prev_blank = (a_seven[6:0] === 7'b1111111);
                end
                if (a_seven[6:0] !== 7'b1111111) check("blink_digit0_lit", 70'(a_seven[6:0]), 70'(seg_tab[2]));
            end
            check("blink_toggles_seen", 70'(runs >= 3), 70'd1);
            a_mask = '0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_bcd_driver.md
Name: seven_seg_bcd_driver

Overview:
- Sequential binary-to-decimal seven-segment driver for DE2-115 HEX displays.
- Accepts an IN_W-bit unsigned value over a valid/ready handshake and converts it with an iterative double-dabble (shift-add-3) engine at one bit per cycle.
- Drives DIGITS registered, active-low segment groups, with optional leading-zero blanking and overflow indication.
- Sits between datapath/status logic and the HEX pins; intended to replace fixed-width lookup decoders.

Parameters:
- IN_W, 16, width of the unsigned binary input (1..32).
- DIGITS, 5, number of decimal digits and seven-segment groups driven (1..10).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  i_value is presented for conversion
- o_ready  output  1  block is idle and will accept on i_valid
- i_value  input  IN_W  unsigned binary value to display
- i_blank_lz  input  1  blank leading zeros; sampled on accept
- o_seven  output  DIGITS*7  segment groups; digit k (0 = ones) is at bits [7k+6:7k]; active-low, bit0 = seg 0 … bit6 = seg 6
- o_done  output  1  one-cycle pulse when o_seven updates
- o_overflow  output  1  held high while the displayed value exceeds 10^DIGITS-1

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values:
  - o_seven all ones (all digits dark)
  - o_ready = 1
  - o_done = 0
  - o_overflow = 0
  - state = IDLE
  - internal shift/BCD registers cleared
- Asserting i_rst mid-conversion aborts the conversion. No o_done is produced and all outputs take their reset values.
- Segment codes (active-low):
  - D0 1000000, D1 1111001, D2 0100100, D3 0110000, D4 0011001
  - D5 0010010, D6 0000010, D7 1011000, D8 0000000, D9 0010000
  - BLANK 1111111, DASH 0111111
- Accept: a transfer occurs on a rising edge with i_valid && o_ready. On accept the block captures:
  - i_value into the shift register
  - i_blank_lz
  - the overflow flag ovf = (i_value > 10^DIGITS-1), with the constant computed at elaboration and widened as needed
- i_valid while o_ready = 0 is ignored; there is no queuing.
- States:
  - IDLE: o_ready = 1. On accept, clear the BCD register (DIGITS*4 bits), set bit counter = IN_W-1, go to CONVERT.
  - CONVERT: o_ready = 0. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shreg} left by 1. After the cycle with counter = 0, go to LOAD; otherwise decrement the counter.
  - LOAD: one cycle. Register o_seven and o_overflow, assert o_done, return to IDLE (o_ready = 1 next cycle).
- Latency:
  - o_seven, o_overflow and o_done change at edge t+IN_W+1, where t is the accept edge.
  - Back-to-back throughput is one value per IN_W+2 cycles.
- LOAD encoding:
  - If ovf: every digit = DASH and o_overflow = 1.
  - Otherwise o_overflow = 0 and each nibble is encoded to D0..D9.
  - If blanking was sampled: every digit above the most significant nonzero digit = BLANK. Digit 0 is never blanked, so value 0 shows a single D0.
  - The BCD arithmetic discards carries beyond DIGITS nibbles; an overflowed value displays dashes only.
- o_seven and o_overflow hold between LOAD cycles.

Optional Feature:
- SEVEN_SEG_BLINK_EN defined adds:
  - parameter BLINK_DIV (default 25_000_000)
  - input i_blink_mask, width DIGITS
  - a free-running counter that toggles a blink phase every BLINK_DIV cycles
- While the phase is 1, each digit whose mask bit is set outputs BLANK instead of its registered code. The final output mux is combinational from the registered code and the registered phase.
- Reset clears the counter and the phase.
- SEVEN_SEG_BLINK_EN undefined: no port, no counter, and the output is identical to the registered code.

Decomposition:
- Package seven_seg_pkg holds:
  - segment constants D0..D9, BLANK, DASH
  - state enum {IDLE, CONVERT, LOAD}
  - function digit_to_seg(4-bit) returning 7-bit, where nibbles > 9 return DASH
- One sub-module, seven_seg_digit_enc: combinational, a 4-bit BCD nibble plus a blank flag in, 7 segment bits out. It is instantiated DIGITS times in a generate loop.

Test Plan:
- IN_W=16, DIGITS=5; accept 12345, blank_lz=0 -> after 17 edges, o_done pulses one cycle; o_seven digits 4..0 = D1, D2, D3, D4, D5; o_overflow=0.
- Accept 7 with blank_lz=1 -> digits 4..1 = 1111111 and digit 0 = 1011000. Accept 0 with blank_lz=1 -> only digit 0 = 1000000.
- IN_W=8, DIGITS=2; accept 100 -> both digits 0111111 and o_overflow=1. Then accept 99 -> D9 D9 and o_overflow=0.
- Pulse i_valid with 500 during CONVERT -> ignored; o_ready=0 for 17 cycles after accept; exactly one o_done, showing the first value.
- Assert i_rst 5 cycles after accepting 4321 -> no o_done; o_seven all ones and o_ready=1 on the cycle after reset releases.
- With SEVEN_SEG_BLINK_EN, BLINK_DIV=4, mask=00001, value 42 -> digit 0 alternates D2/BLANK every 4 cycles while digit 1 stays D4.
